// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter: queue entry, FSM states and a
// destination-to-mask helper. Used by wb_fifo and regfile_writeback_arbiter.
package wb_pkg;

    localparam int REG_COUNT = 32;
    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 64;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WRITE = 2'd1,
        WB_ACK   = 2'd2
    } wb_state_e;

    function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [WB_ADDR_W-1:0] addr);
        logic [REG_COUNT-1:0] mask;
        mask = {REG_COUNT{1'b0}};
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback queue of wb_entry_t. Exposes the raw entry array, per-slot valid bits and
// the read pointer so the owner can build the busy mask and age-ordered searches.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output wb_entry_t [DEPTH-1:0]    entries,
    output logic [DEPTH-1:0]         valid,
    output logic [$clog2(DEPTH)-1:0] rd_ptr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [DEPTH-1:0]      valid_r;
    wb_entry_t [DEPTH-1:0] mem_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Per-slot valid bits; push and pop never target the same slot in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= {DEPTH{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_ok_s && (wr_ptr_r == PTR_W'(i))) begin
                    valid_r[i] <= 1'b1;
                end else if (pop_ok_s && (rd_ptr_r == PTR_W'(i))) begin
                    valid_r[i] <= 1'b0;
                end
            end
        end
    end

    // Entry storage; contents are only meaningful where the valid bit is set.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

    assign entries = mem_r;
    assign valid   = valid_r;
    assign rd_ptr  = rd_ptr_r;

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Writeback master for the 32x64 register file: arbitrates load/ALU results into wb_fifo and
// retires them one at a time. Optional bypass search ports are enabled by defining WB_BYPASS_EN.
module regfile_writeback_arbiter
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  rf_write_enable,
    output logic [ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    input  logic                  rf_write_complete,
    output logic [31:0]           busy_mask,
    output logic                  idle
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_WIDTH-1:0] byp_addr1,
    input  logic [ADDR_WIDTH-1:0] byp_addr2,
    output logic                  byp_hit1,
    output logic                  byp_hit2,
    output logic [DATA_WIDTH-1:0] byp_data1,
    output logic [DATA_WIDTH-1:0] byp_data2
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_state_e             state_r;
    logic                  full_s;
    logic                  empty_s;
    wb_entry_t [DEPTH-1:0] entries_s;
    logic [DEPTH-1:0]      valid_s;
    logic [PTR_W-1:0]      rd_ptr_s;
    wb_entry_t             head_s;
    wb_entry_t             push_entry_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  take_mem_s;
    logic                  take_alu_s;
    logic [REG_COUNT-1:0]  mask_s;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .full       (full_s),
        .empty      (empty_s),
        .entries    (entries_s),
        .valid      (valid_s),
        .rd_ptr     (rd_ptr_s)
    );

    // Loads win over ALU results because the load is the older instruction.
    assign mem_ready = !full_s;
    assign alu_ready = !full_s && !mem_valid;
    assign head_s    = entries_s[rd_ptr_s];
    assign pop_s     = (state_r == WB_ACK) && rf_write_complete;

    // Select the accepted source; rd==0 completes the handshake but is never queued.
    always_comb begin
        take_mem_s        = mem_valid && !full_s;
        take_alu_s        = alu_valid && !full_s && !mem_valid;
        push_entry_s.addr = WB_ADDR_W'(alu_addr);
        push_entry_s.data = WB_DATA_W'(alu_data);
        push_s            = 1'b0;
        if (take_mem_s) begin
            push_entry_s.addr = WB_ADDR_W'(mem_addr);
            push_entry_s.data = WB_DATA_W'(mem_data);
            push_s            = (mem_addr != {ADDR_WIDTH{1'b0}});
        end else if (take_alu_s) begin
            push_s            = (alu_addr != {ADDR_WIDTH{1'b0}});
        end else begin
            push_s            = 1'b0;
        end
    end

    // Write FSM: one-cycle strobe of the head, then wait for the file's ack before popping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= WB_IDLE;
            rf_write_enable <= 1'b0;
            rf_write_addr   <= {ADDR_WIDTH{1'b0}};
            rf_write_data   <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                WB_IDLE: begin
                    if (!empty_s) begin
                        state_r         <= WB_WRITE;
                        rf_write_enable <= 1'b1;
                        rf_write_addr   <= ADDR_WIDTH'(head_s.addr);
                        rf_write_data   <= DATA_WIDTH'(head_s.data);
                    end else begin
                        rf_write_enable <= 1'b0;
                    end
                end
                WB_WRITE: begin
                    state_r         <= WB_ACK;
                    rf_write_enable <= 1'b0;
                end
                WB_ACK: begin
                    rf_write_enable <= 1'b0;
                    if (rf_write_complete) begin
                        state_r <= WB_IDLE;
                    end
                end
                default: begin
                    state_r         <= WB_IDLE;
                    rf_write_enable <= 1'b0;
                end
            endcase
        end
    end

    // Busy mask covers every queued entry, including the head while it is being written.
    always_comb begin
        mask_s = {REG_COUNT{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            mask_s = mask_s | (valid_s[i] ? reg_onehot(entries_s[i].addr) : {REG_COUNT{1'b0}});
        end
        mask_s[0] = 1'b0;
    end

    assign busy_mask = mask_s;
    assign idle      = empty_s && (state_r == WB_IDLE);

`ifdef WB_BYPASS_EN
    // Walk oldest to youngest so the last match (youngest writer) wins.
    function automatic logic [DATA_WIDTH:0] byp_search(
        input logic [ADDR_WIDTH-1:0] addr,
        input wb_entry_t [DEPTH-1:0] ents,
        input logic [DEPTH-1:0]      vld,
        input logic [PTR_W-1:0]      oldest
    );
        logic [DATA_WIDTH:0] res;
        logic [PTR_W-1:0]    idx;
        logic                match;
        res = {(DATA_WIDTH+1){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx   = oldest + PTR_W'(i);
            match = vld[idx] && (addr != {ADDR_WIDTH{1'b0}})
                    && (ents[idx].addr == WB_ADDR_W'(addr));
            res   = match ? {1'b1, DATA_WIDTH'(ents[idx].data)} : res;
        end
        return res;
    endfunction

    assign {byp_hit1, byp_data1} = byp_search(byp_addr1, entries_s, valid_s, rd_ptr_s);
    assign {byp_hit2, byp_data2} = byp_search(byp_addr2, entries_s, valid_s, rd_ptr_s);
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter: directed scenarios plus a randomized run,
// checked against a queue-based model and a register-file responder that acks one cycle late.
module tb_regfile_writeback_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_addr = 5'd0;
    logic [63:0] mem_data = 64'd0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_addr = 5'd0;
    logic [63:0] alu_data = 64'd0;
    logic        mem_ready;
    logic        alu_ready;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [63:0] rf_write_data;
    logic        rf_write_complete = 1'b0;
    logic [31:0] busy_mask;
    logic        idle;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_addr1 = 5'd0;
    logic [4:0]  byp_addr2 = 5'd0;
    logic        byp_hit1;
    logic        byp_hit2;
    logic [63:0] byp_data1;
    logic [63:0] byp_data2;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    int          strobe_err = 0;
    logic [68:0] model_q[$];
    logic [68:0] exp_q[$];
    logic [68:0] got_q[$];
    logic [63:0] rf_model [32];
    bit          hold_ack = 1'b0;
    bit          ack_pending = 1'b0;
    bit          prev_en = 1'b0;

    regfile_writeback_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .mem_valid         (mem_valid),
        .mem_ready         (mem_ready),
        .mem_addr          (mem_addr),
        .mem_data          (mem_data),
        .alu_valid         (alu_valid),
        .alu_ready         (alu_ready),
        .alu_addr          (alu_addr),
        .alu_data          (alu_data),
        .rf_write_enable   (rf_write_enable),
        .rf_write_addr     (rf_write_addr),
        .rf_write_data     (rf_write_data),
        .rf_write_complete (rf_write_complete),
        .busy_mask         (busy_mask),
        .idle              (idle)
`ifdef WB_BYPASS_EN
        ,
        .byp_addr1         (byp_addr1),
        .byp_addr2         (byp_addr2),
        .byp_hit1          (byp_hit1),
        .byp_hit2          (byp_hit2),
        .byp_data1         (byp_data1),
        .byp_data2         (byp_data2)
`endif
    );

    always #5 clk = ~clk;

    // Register file model: records each strobe and acks it on the following cycle unless held.
    always @(negedge clk) begin
        if (ack_pending && !hold_ack) begin
            rf_write_complete = 1'b1;
            ack_pending = 1'b0;
        end else begin
            rf_write_complete = 1'b0;
        end
        if (rf_write_enable === 1'b1) begin
            if (prev_en) strobe_err++;
            rf_model[rf_write_addr] = rf_write_data;
            got_q.push_back({rf_write_addr, rf_write_data});
            ack_pending = 1'b1;
        end
        prev_en = (rf_write_enable === 1'b1);
    end

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = 32'd0;
        foreach (model_q[i]) m[model_q[i][68:64]] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // One clock: apply the handshake/retire rules to the model at the edge, return after negedge.
    task automatic tick();
        bit room, hs_m, hs_a, do_pop;
        room   = (model_q.size() < DEPTH);
        hs_m   = mem_valid && room;
        hs_a   = alu_valid && !mem_valid && room;
        do_pop = rf_write_complete && (model_q.size() > 0);
        @(posedge clk);
        if (reset) begin
            model_q.delete();
            while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (hs_m && mem_addr != 5'd0) begin
                model_q.push_back({mem_addr, mem_data});
                exp_q.push_back({mem_addr, mem_data});
            end else if (hs_a && alu_addr != 5'd0) begin
                model_q.push_back({alu_addr, alu_data});
                exp_q.push_back({alu_addr, alu_data});
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin n_bad++;
            $display("FAIL reset_ready: got %b/%b want 1/1", mem_ready, alu_ready); end
        n_cmp++; if (rf_write_addr !== 5'd0 || rf_write_data !== 64'd0) begin n_bad++;
            $display("FAIL reset_wr_bus: got %h/%h want 0/0", rf_write_addr, rf_write_data); end
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++; if (rf_write_enable !== 1'b0 || idle !== 1'b1 || busy_mask !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_idle: got en=%b idle=%b mask=%h want 0/1/0",
                         rf_write_enable, idle, busy_mask);
            end
        end
    endtask

    task automatic test_single_alu();
        int base;
        base = got_q.size();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 64'hDEAD_BEEF;
        #1;
        n_cmp++; if (alu_ready !== 1'b1) begin n_bad++;
            $display("FAIL single_ready: got %b want 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        n_cmp++; if (rf_write_enable !== 1'b0 || busy_mask !== 32'h20 || idle !== 1'b0) begin
            n_bad++;
            $display("FAIL single_queued: got en=%b mask=%h idle=%b want 0/20/0",
                     rf_write_enable, busy_mask, idle);
        end
        tick();
        n_cmp++; if (rf_write_enable !== 1'b1 || rf_write_addr !== 5'd5
                     || rf_write_data !== 64'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL single_strobe: got en=%b a=%0d d=%h want 1/5/deadbeef",
                     rf_write_enable, rf_write_addr, rf_write_data);
        end
        tick();
        n_cmp++; if (rf_write_enable !== 1'b0 || busy_mask !== 32'h20) begin n_bad++;
            $display("FAIL single_ack: got en=%b mask=%h want 0/20", rf_write_enable, busy_mask); end
        tick();
        n_cmp++; if (busy_mask !== 32'd0 || idle !== 1'b1) begin n_bad++;
            $display("FAIL single_retire: got mask=%h idle=%b want 0/1", busy_mask, idle); end
        n_cmp++; if (rf_model[5] !== 64'hDEAD_BEEF || got_q.size() != base + 1) begin n_bad++;
            $display("FAIL single_file: got x5=%h writes=%0d want deadbeef/%0d",
                     rf_model[5], got_q.size() - base, 1);
        end
    endtask

    task automatic test_simultaneous();
        int base;
        base = got_q.size();
        mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 64'hFFFF_FFFF_FFFF_FFFF;
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 64'd7;
        #1;
        n_cmp++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin n_bad++;
            $display("FAIL simul_ready: got %b/%b want 1/0", mem_ready, alu_ready); end
        tick();
        mem_valid = 1'b0;
        #1;
        n_cmp++; if (alu_ready !== 1'b1) begin n_bad++;
            $display("FAIL simul_alu_ready: got %b want 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        for (int k = 0; k < 60 && model_q.size() != 0; k++) tick();
        n_cmp++; if (got_q.size() != base + 2 || idle !== 1'b1) begin n_bad++;
            $display("FAIL simul_drain: got writes=%0d idle=%b want 2/1", got_q.size() - base, idle);
        end else begin
            n_cmp++; if (got_q[base] !== {5'd3, 64'hFFFF_FFFF_FFFF_FFFF}
                         || got_q[base+1] !== {5'd4, 64'd7}) begin
                n_bad++;
                $display("FAIL simul_order: got %h,%h want x3=-1 then x4=7",
                         got_q[base], got_q[base+1]);
            end
        end
    endtask

    task automatic test_full_backpressure();
        int base;
        base = got_q.size();
        hold_ack = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            alu_valid = 1'b1; alu_addr = 5'(10 + i); alu_data = {$urandom(), $urandom()};
            tick();
        end
        mem_valid = 1'b1; mem_addr = 5'd20; alu_addr = 5'd21;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (mem_ready !== 1'b0 || alu_ready !== 1'b0) begin n_bad++;
                $display("FAIL full_ready: got %b/%b want 0/0", mem_ready, alu_ready); end
            tick();
            n_cmp++; if (busy_mask !== 32'h0000_3C00) begin n_bad++;
                $display("FAIL full_mask: got %h want 00003c00", busy_mask); end
        end
        mem_valid = 1'b0; alu_valid = 1'b0;
        hold_ack = 1'b0;
        for (int k = 0; k < 40 && model_q.size() != 0; k++) begin
            n_cmp++; if (mem_ready !== (model_q.size() < DEPTH)
                         || alu_ready !== (model_q.size() < DEPTH)) begin
                n_bad++;
                $display("FAIL full_release_ready: got %b/%b want %b", mem_ready, alu_ready,
                         model_q.size() < DEPTH);
            end
            tick();
            n_cmp++; if (busy_mask !== model_mask()) begin n_bad++;
                $display("FAIL full_release_mask: got %h want %h", busy_mask, model_mask()); end
        end
        n_cmp++; if (got_q.size() != base + DEPTH || idle !== 1'b1) begin n_bad++;
            $display("FAIL full_drain: got writes=%0d idle=%b want %0d/1",
                     got_q.size() - base, idle, DEPTH);
        end
        for (int j = base; j < got_q.size() && j < exp_q.size(); j++) begin
            n_cmp++; if (got_q[j] !== exp_q[j]) begin n_bad++;
                $display("FAIL full_order[%0d]: got %h want %h", j, got_q[j], exp_q[j]); end
        end
    endtask

    task automatic test_rd_zero_dup();
        int base;
        base = got_q.size();
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 64'd99;
        #1;
        n_cmp++; if (alu_ready !== 1'b1) begin n_bad++;
            $display("FAIL rd0_ready: got %b want 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        n_cmp++; if (busy_mask !== 32'd0 || idle !== 1'b1) begin n_bad++;
            $display("FAIL rd0_queue: got mask=%h idle=%b want 0/1", busy_mask, idle); end
        for (int c = 0; c < 4; c++) tick();
        n_cmp++; if (got_q.size() != base) begin n_bad++;
            $display("FAIL rd0_strobe: got %0d writes want 0", got_q.size() - base); end
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 64'd1;
        tick();
        alu_data = 64'd2;
        tick();
        alu_valid = 1'b0;
        for (int k = 0; k < 40 && model_q.size() != 0; k++) begin
            n_cmp++; if (busy_mask !== model_mask()) begin n_bad++;
                $display("FAIL dup_mask: got %h want %h", busy_mask, model_mask()); end
            tick();
        end
        n_cmp++; if (rf_model[9] !== 64'd2 || busy_mask !== 32'd0 || got_q.size() != base + 2)
        begin
            n_bad++;
            $display("FAIL dup_final: got x9=%0d mask=%h writes=%0d want 2/0/2",
                     rf_model[9], busy_mask, got_q.size() - base);
        end
    endtask

    task automatic test_random();
        int base;
        base = got_q.size();
        for (int c = 0; c < 400; c++) begin
            hold_ack  = ($urandom_range(0, 3) == 0);
            mem_valid = ($urandom_range(0, 2) == 0);
            mem_addr  = 5'($urandom_range(0, 31));
            mem_data  = {$urandom(), $urandom()};
            alu_valid = ($urandom_range(0, 1) == 0);
            alu_addr  = 5'($urandom_range(0, 31));
            alu_data  = {$urandom(), $urandom()};
            #1;
            n_cmp++; if (mem_ready !== (model_q.size() < DEPTH)
                         || alu_ready !== ((model_q.size() < DEPTH) && !mem_valid)) begin
                n_bad++;
                $display("FAIL rand_ready: got %b/%b qlen=%0d mv=%b", mem_ready, alu_ready,
                         model_q.size(), mem_valid);
            end
            tick();
            n_cmp++; if (busy_mask !== model_mask() || idle !== (model_q.size() == 0)) begin
                n_bad++;
                $display("FAIL rand_state: got mask=%h idle=%b want %h/%b", busy_mask, idle,
                         model_mask(), model_q.size() == 0);
            end
        end
        mem_valid = 1'b0; alu_valid = 1'b0; hold_ack = 1'b0;
        for (int k = 0; k < 60 && model_q.size() != 0; k++) tick();
        n_cmp++; if (got_q.size() != exp_q.size() || idle !== 1'b1) begin n_bad++;
            $display("FAIL rand_drain: got writes=%0d idle=%b want %0d/1",
                     got_q.size(), idle, exp_q.size());
        end
        for (int j = base; j < got_q.size() && j < exp_q.size(); j++) begin
            n_cmp++; if (got_q[j] !== exp_q[j]) begin n_bad++;
                $display("FAIL rand_order[%0d]: got %h want %h", j, got_q[j], exp_q[j]); end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        base = got_q.size();
        hold_ack = 1'b1;
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 64'd1;
        tick();
        alu_data = 64'd2;
        tick();
        alu_addr = 5'd7; alu_data = 64'd5;
        tick();
        alu_valid = 1'b0;
        for (int k = 0; k < 10 && got_q.size() == base; k++) tick();
        tick();
        n_cmp++; if (got_q.size() != base + 1 || rf_write_enable !== 1'b0
                     || busy_mask !== 32'h0000_0280) begin
            n_bad++;
            $display("FAIL mid_ack_state: got writes=%0d en=%b mask=%h want 1/0/00000280",
                     got_q.size() - base, rf_write_enable, busy_mask);
        end
`ifdef WB_BYPASS_EN
        byp_addr1 = 5'd9; byp_addr2 = 5'd7;
        #1;
        n_cmp++; if (byp_hit1 !== 1'b1 || byp_data1 !== 64'd2) begin n_bad++;
            $display("FAIL byp_youngest: got hit=%b d=%0d want 1/2", byp_hit1, byp_data1); end
        n_cmp++; if (byp_hit2 !== 1'b1 || byp_data2 !== 64'd5) begin n_bad++;
            $display("FAIL byp_hit2: got hit=%b d=%0d want 1/5", byp_hit2, byp_data2); end
        byp_addr1 = 5'd0; byp_addr2 = 5'd6;
        #1;
        n_cmp++; if (byp_hit1 !== 1'b0 || byp_data1 !== 64'd0
                     || byp_hit2 !== 1'b0 || byp_data2 !== 64'd0) begin
            n_bad++;
            $display("FAIL byp_miss: got %b/%0d %b/%0d want 0/0 0/0",
                     byp_hit1, byp_data1, byp_hit2, byp_data2);
        end
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (idle !== 1'b1 || busy_mask !== 32'd0 || mem_ready !== 1'b1
                     || rf_write_enable !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: got idle=%b mask=%h mrdy=%b en=%b want 1/0/1/0",
                     idle, busy_mask, mem_ready, rf_write_enable);
        end
        hold_ack = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++; if (rf_write_enable !== 1'b0 || idle !== 1'b1 || got_q.size() != base + 1)
            begin
                n_bad++;
                $display("FAIL mid_after: got en=%b idle=%b writes=%0d want 0/1/1",
                         rf_write_enable, idle, got_q.size() - base);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        #1;
        test_reset();
        test_single_alu();
        test_simultaneous();
        test_full_backpressure();
        test_rd_zero_dup();
        test_random();
        test_reset_mid();
        n_cmp++; if (strobe_err != 0) begin n_bad++;
            $display("FAIL strobe_width: got %0d multi-cycle strobes want 0", strobe_err); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
